axi_dma_rd: RTL
===============

Name: axi_dma_rd

Overview:
AXI4 read-master DMA that fetches input feature maps / weights from DRAM and streams them, one 32-bit word per beat, into the on-chip buffer write port.
- Counterpart of the output-feature-map write DMA; shares its user-interface style (start_dma / done_o / num_trans / start_addr / fail_check).
- Single outstanding burst, INCR, full-width transfers.
- Registered 2-entry skid stage on the output side so downstream back-pressure never combinationally reaches M_RREADY.

Parameters:
- BITS_TRANS, 18, width of num_trans (max words per job = 2^18-1)
- AXI_WIDTH_ID, 4, ID width
- AXI_WIDTH_AD, 32, address width
- AXI_WIDTH_DA, 32, data width (only 32 supported)
- FIXED_BURST_SIZE, 256, max beats per burst (1..256)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- M_ARVALID/M_ARREADY  out/in  1  read address handshake
- M_ARADDR  out  AXI_WIDTH_AD  burst start byte address
- M_ARID  out  AXI_WIDTH_ID  constant 0
- M_ARLEN  out  8  beats-1
- M_ARSIZE  out  3  constant 3'b010 while ARVALID, else 0
- M_ARBURST/M_ARLOCK/M_ARCACHE/M_ARPROT/M_ARQOS/M_ARREGION/M_ARUSER  out  2/2/4/3/4/4/4  constants 01/00/0000/000/1111/0000/0000
- M_RVALID/M_RREADY  in/out  1  read data handshake
- M_RDATA  in  AXI_WIDTH_DA  read data
- M_RRESP  in  2  per-beat response
- M_RLAST  in  1  last beat
- M_RID  in  AXI_WIDTH_ID  ignored
- M_RUSER  in  1  ignored
- start_dma  in  1  one-cycle job start pulse
- num_trans  in  BITS_TRANS  words to read, sampled on start_dma
- start_addr  in  AXI_WIDTH_AD  byte address (4-byte aligned), sampled on start_dma
- outdata  out  AXI_WIDTH_DA  data to buffer
- outdata_valid  out  1  outdata valid
- outdata_rdy  in  1  buffer accepts outdata
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle pulse, job complete
- fail_check  out  1  one-cycle pulse per non-OKAY beat (debug)

Behaviour:
- Reset: all outputs 0, FSM RD_IDLE, counters 0, skid empty. Reset mid-job aborts immediately; ARVALID/RREADY drop asynchronously; no done_o.
- FSM RD_IDLE -> RD_PRE -> RD_START -> RD_SEQ -> RD_PRE ...
  - RD_IDLE: on start_dma, latch num_trans, start_addr; busy_o=1; go to RD_PRE. start_dma outside RD_IDLE is ignored.
  - RD_PRE:
    - remaining = num_trans_q - beats_issued.
    - If remaining == 0, wait for skid empty, then pulse done_o, clear busy_o, go to RD_IDLE.
    - Otherwise latch len = (remaining >= FIXED_BURST_SIZE) ? FIXED_BURST_SIZE-1 : remaining-1, computed at full width; go to RD_START.
  - RD_START: ARVALID=1 with ARADDR=addr_q, ARLEN=len, held stable until ARREADY. On handshake go to RD_SEQ.
  - RD_SEQ:
    - M_RREADY = skid not full (registered).
    - Each R handshake pushes RDATA into the skid and increments beat_cnt.
    - At beat_cnt == len: addr_q += (len+1)*4 (AXI_WIDTH_AD wrap), beats_issued += len+1, beat_cnt = 0, go to RD_PRE.
- Errors: non-OKAY RRESP still delivers data and counts the beat; pulse fail_check the same cycle; no retry.
- Skid: outdata_valid one cycle after an R handshake; ordering preserved; simultaneous push and pop while full is legal; throughput 1 word/cycle when outdata_rdy is held high.
- num_trans = 0: RD_IDLE -> RD_PRE -> done_o on cycle 2 after start; no AR issued.
- No 4KB-boundary splitting. Software guarantees bursts do not cross 4KB.

Optional Feature:
AXI_DMA_RD_LAST_CHK_EN
- Defined:
  - M_RLAST is compared against (beat_cnt == len) on every R handshake.
  - A mismatch sets a sticky last_err flag, cleared by start_dma, and pulses fail_check.
  - Beat counting stays driven by beat_cnt, not by RLAST.
- Undefined: M_RLAST is ignored; no last_err logic is synthesised.

Decomposition:
- Shared package axi_dma_pkg: AXI SIZE_* and RESP_* codes, AR constant field values, FSM state encodings (RD_IDLE..RD_SEQ).
- One sub-module, axi_dma_rd_skid: 2-entry registered FIFO with push/full and pop/valid, parameterised width.

Test Plan:
- num_trans=600, start_addr=0x1000_0000, slave always ready -> 3 ARs: (0x1000_0000, len 255), (0x1000_0400, len 255), (0x1000_0800, len 87); 600 words in order; done_o once.
- num_trans=256 -> exactly 1 AR with len 255; next RD_PRE goes straight to done; no zero-length AR.
- num_trans=0 -> no ARVALID ever; done_o pulse 2 cycles after start_dma.
- outdata_rdy toggling randomly with RVALID gaps, num_trans=300 -> no lost or duplicated words; RREADY low whenever skid full; data matches DRAM model.
- Slave returns SLVERR on beat 10 of burst 1 -> one fail_check pulse; all words still delivered; done_o asserted.
- rst asserted mid-RD_SEQ, then a new start with num_trans=4 -> all outputs 0 during reset; clean single AR with len 3; done_o.

Source files
------------

// File: rtl/axi_dma_pkg.sv
// Shared definitions for the AXI4 read DMA: AXI encodings, constant AR fields
// and the read-FSM state type.
package axi_dma_pkg;

  localparam logic [2:0] SIZE_1B = 3'b000;
  localparam logic [2:0] SIZE_2B = 3'b001;
  localparam logic [2:0] SIZE_4B = 3'b010;
  localparam logic [2:0] SIZE_8B = 3'b011;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] AR_BURST_INCR = 2'b01;
  localparam logic [1:0] AR_LOCK_VAL   = 2'b00;
  localparam logic [3:0] AR_CACHE_VAL  = 4'b0000;
  localparam logic [2:0] AR_PROT_VAL   = 3'b000;
  localparam logic [3:0] AR_QOS_VAL    = 4'b1111;
  localparam logic [3:0] AR_REGION_VAL = 4'b0000;
  localparam logic [3:0] AR_USER_VAL   = 4'b0000;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_PRE   = 2'd1,
    RD_START = 2'd2,
    RD_SEQ   = 2'd3
  } rd_state_e;

endpackage

// File: rtl/axi_dma_rd_if.sv
// AXI4 read-channel bundle (AR + R) between the read DMA (master) and DRAM
// port (slave).
interface axi_dma_rd_if #(
  parameter int AXI_WIDTH_ID = 4,
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_DA = 32
) ();

  logic                    M_ARVALID;
  logic                    M_ARREADY;
  logic [AXI_WIDTH_AD-1:0] M_ARADDR;
  logic [AXI_WIDTH_ID-1:0] M_ARID;
  logic [7:0]              M_ARLEN;
  logic [2:0]              M_ARSIZE;
  logic [1:0]              M_ARBURST;
  logic [1:0]              M_ARLOCK;
  logic [3:0]              M_ARCACHE;
  logic [2:0]              M_ARPROT;
  logic [3:0]              M_ARQOS;
  logic [3:0]              M_ARREGION;
  logic [3:0]              M_ARUSER;

  logic                    M_RVALID;
  logic                    M_RREADY;
  logic [AXI_WIDTH_DA-1:0] M_RDATA;
  logic [1:0]              M_RRESP;
  logic                    M_RLAST;
  logic [AXI_WIDTH_ID-1:0] M_RID;
  logic                    M_RUSER;

  modport master (
    output M_ARVALID, M_ARADDR, M_ARID, M_ARLEN, M_ARSIZE, M_ARBURST,
           M_ARLOCK, M_ARCACHE, M_ARPROT, M_ARQOS, M_ARREGION, M_ARUSER,
           M_RREADY,
    input  M_ARREADY, M_RVALID, M_RDATA, M_RRESP, M_RLAST, M_RID, M_RUSER
  );

  modport slave (
    input  M_ARVALID, M_ARADDR, M_ARID, M_ARLEN, M_ARSIZE, M_ARBURST,
           M_ARLOCK, M_ARCACHE, M_ARPROT, M_ARQOS, M_ARREGION, M_ARUSER,
           M_RREADY,
    output M_ARREADY, M_RVALID, M_RDATA, M_RRESP, M_RLAST, M_RID, M_RUSER
  );

endinterface

// File: rtl/axi_dma_rd_skid.sv
// Two-entry registered FIFO decoupling the AXI R channel from the buffer
// write port; full and valid come straight from the occupancy register.
module axi_dma_rd_skid #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] pop_data
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  // A push while full is accepted when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full     = (count_q == 2'd2);
  assign valid    = (count_q != 2'd0);
  assign pop_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/axi_dma_rd.sv
// AXI4 read-master DMA: single outstanding INCR burst, one 32-bit word per beat
// into the buffer. Optional RLAST checking under AXI_DMA_RD_LAST_CHK_EN.
module axi_dma_rd
  import axi_dma_pkg::*;
#(
  parameter int BITS_TRANS       = 18,
  parameter int AXI_WIDTH_ID     = 4,
  parameter int AXI_WIDTH_AD     = 32,
  parameter int AXI_WIDTH_DA     = 32,
  parameter int FIXED_BURST_SIZE = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_dma_rd_if.master            m_axi,
  input  logic                    start_dma,
  input  logic [BITS_TRANS-1:0]   num_trans,
  input  logic [AXI_WIDTH_AD-1:0] start_addr,
  output logic [AXI_WIDTH_DA-1:0] outdata,
  output logic                    outdata_valid,
  input  logic                    outdata_rdy,
  output logic                    busy_o,
  output logic                    done_o,
`ifdef AXI_DMA_RD_LAST_CHK_EN
  output logic                    last_err,
`endif
  output logic                    fail_check
);

  localparam logic [BITS_TRANS-1:0] BURST_MAX = BITS_TRANS'(FIXED_BURST_SIZE);

  rd_state_e               state_q, state_d;
  logic [BITS_TRANS-1:0]   num_trans_q, num_trans_d;
  logic [BITS_TRANS-1:0]   beats_issued_q, beats_issued_d;
  logic [AXI_WIDTH_AD-1:0] addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              beat_cnt_q, beat_cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    skid_full, skid_valid;
  logic                    rready, r_hs, burst_last, bad_resp;
  logic [BITS_TRANS-1:0]   remaining;
  logic [8:0]              burst_beats;

  assign rready      = (state_q == RD_SEQ) && !skid_full;
  assign r_hs        = m_axi.M_RVALID && rready;
  assign burst_last  = (beat_cnt_q == len_q);
  assign remaining   = num_trans_q - beats_issued_q;
  assign burst_beats = {1'b0, len_q} + 9'd1;
  assign bad_resp    = r_hs && (m_axi.M_RRESP != RESP_OKAY);

  // Job sequencing: size the next burst, issue AR, count beats, then repeat.
  always_comb begin
    state_d        = state_q;
    num_trans_d    = num_trans_q;
    beats_issued_d = beats_issued_q;
    addr_d         = addr_q;
    len_d          = len_q;
    beat_cnt_d     = beat_cnt_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (start_dma) begin
          num_trans_d    = num_trans;
          addr_d         = start_addr;
          beats_issued_d = '0;
          beat_cnt_d     = 8'd0;
          busy_d         = 1'b1;
          state_d        = RD_PRE;
        end
      end
      RD_PRE: begin
        if (remaining == '0) begin
          if (!skid_valid) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = RD_IDLE;
          end
        end else begin
          len_d   = (remaining >= BURST_MAX) ? 8'(FIXED_BURST_SIZE - 1)
                                             : 8'(remaining - BITS_TRANS'(1));
          state_d = RD_START;
        end
      end
      RD_START: begin
        if (m_axi.M_ARREADY) begin
          state_d = RD_SEQ;
        end
      end
      RD_SEQ: begin
        if (r_hs) begin
          if (burst_last) begin
            addr_d         = addr_q + (AXI_WIDTH_AD'(burst_beats) << 2);
            beats_issued_d = beats_issued_q + BITS_TRANS'(burst_beats);
            beat_cnt_d     = 8'd0;
            state_d        = RD_PRE;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RD_IDLE;
      num_trans_q    <= '0;
      beats_issued_q <= '0;
      addr_q         <= '0;
      len_q          <= 8'd0;
      beat_cnt_q     <= 8'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      num_trans_q    <= num_trans_d;
      beats_issued_q <= beats_issued_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      beat_cnt_q     <= beat_cnt_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

`ifdef AXI_DMA_RD_LAST_CHK_EN
  logic last_mis;
  logic last_err_q, last_err_d;

  // RLAST is only cross-checked; beat counting never follows it.
  always_comb begin
    last_mis   = r_hs && (m_axi.M_RLAST != burst_last);
    last_err_d = last_err_q;
    if ((state_q == RD_IDLE) && start_dma) begin
      last_err_d = 1'b0;
    end else if (last_mis) begin
      last_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_err_q <= 1'b0;
    end else begin
      last_err_q <= last_err_d;
    end
  end

  assign last_err   = last_err_q;
  assign fail_check = bad_resp || last_mis;

  logic unused_r_fields;
  assign unused_r_fields = ^{m_axi.M_RID, m_axi.M_RUSER};
`else
  assign fail_check = bad_resp;

  logic unused_r_fields;
  assign unused_r_fields = ^{m_axi.M_RID, m_axi.M_RUSER, m_axi.M_RLAST};
`endif

  axi_dma_rd_skid #(
    .WIDTH (AXI_WIDTH_DA)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (r_hs),
    .push_data (m_axi.M_RDATA),
    .full      (skid_full),
    .pop       (outdata_rdy),
    .valid     (skid_valid),
    .pop_data  (outdata)
  );

  assign outdata_valid = skid_valid;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

  assign m_axi.M_ARVALID  = (state_q == RD_START);
  assign m_axi.M_ARADDR   = addr_q;
  assign m_axi.M_ARLEN    = len_q;
  assign m_axi.M_ARID     = '0;
  assign m_axi.M_ARSIZE   = (state_q == RD_START) ? SIZE_4B : 3'b000;
  assign m_axi.M_ARBURST  = AR_BURST_INCR;
  assign m_axi.M_ARLOCK   = AR_LOCK_VAL;
  assign m_axi.M_ARCACHE  = AR_CACHE_VAL;
  assign m_axi.M_ARPROT   = AR_PROT_VAL;
  assign m_axi.M_ARQOS    = AR_QOS_VAL;
  assign m_axi.M_ARREGION = AR_REGION_VAL;
  assign m_axi.M_ARUSER   = AR_USER_VAL;
  assign m_axi.M_RREADY   = rready;

endmodule
